// File: rtl/ram32_arbiter.sv
// ram32_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a single-port
//   RAM with asynchronous read and clock-edge write. Each accepted command
//   takes one BUSY cycle on the RAM bus. Read data comes back with a one-cycle
//   rvalid pulse. Out-of-range addresses get an err pulse and never enable
//   the RAM.
//
//   Ports
//     clk, rst_n            clock (rising edge), synchronous active-low reset
//     a_* / b_*             requester command in (req, we, adr, din) and
//                           response out (gnt, rvalid, dout, err)
//     ram_en, ram_we,
//     ram_adr, ram_din      RAM command bus (address zero-extended)
//     ram_dout              RAM combinational read data
module ram32_arbiter #(
  parameter int DATA_W    = 33,
  parameter int ADDR_W    = 10,
  parameter int RAM_ADR_W = 33,
  parameter int DEPTH     = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_W-1:0]    a_adr,
  input  logic [DATA_W-1:0]    a_din,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [DATA_W-1:0]    a_dout,
  output logic                 a_err,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_W-1:0]    b_adr,
  input  logic [DATA_W-1:0]    b_din,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_W-1:0]    b_dout,
  output logic                 b_err,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [RAM_ADR_W-1:0] ram_adr,
  output logic [DATA_W-1:0]    ram_din,
  input  logic [DATA_W-1:0]    ram_dout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t              state;
  logic                last_b;   // 1: B was served last, so A wins a tie
  logic                cmd_b;    // latched winner
  logic                cmd_we;
  logic                cmd_ok;   // latched address was in range
  logic [ADDR_W-1:0]   cmd_adr;
  logic [DATA_W-1:0]   cmd_din;
  logic                en_q;

  logic                pick_b;
  logic [ADDR_W-1:0]   win_adr;
  logic                win_ok;

  always_comb begin
    pick_b  = b_req && (!a_req || !last_b);
    win_adr = pick_b ? b_adr : a_adr;
    win_ok  = (32'(win_adr) < DEPTH_U);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      cmd_b    <= 1'b0;
      cmd_we   <= 1'b0;
      cmd_ok   <= 1'b0;
      cmd_adr  <= '0;
      cmd_din  <= '0;
      en_q     <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_dout   <= '0;
      b_dout   <= '0;
    end else begin
      // all status outputs are single-cycle pulses
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      en_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            state   <= BUSY;
            last_b  <= pick_b;
            cmd_b   <= pick_b;
            cmd_we  <= pick_b ? b_we  : a_we;
            cmd_din <= pick_b ? b_din : a_din;
            cmd_adr <= win_adr;
            cmd_ok  <= win_ok;
            en_q    <= win_ok;
            a_gnt   <= !pick_b;
            b_gnt   <= pick_b;
          end
        end
        BUSY: begin
          state <= IDLE;
          if (!cmd_ok) begin
            a_err <= !cmd_b;
            b_err <= cmd_b;
          end else if (!cmd_we) begin
            if (cmd_b) begin
              b_dout   <= ram_dout;
              b_rvalid <= 1'b1;
            end else begin
              a_dout   <= ram_dout;
              a_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps a write from committing at an edge where reset
  // is sampled, since the RAM itself never sees reset.
  assign ram_en  = en_q & rst_n;
  assign ram_we  = cmd_we;
  assign ram_adr = {{(RAM_ADR_W-ADDR_W){1'b0}}, cmd_adr};
  assign ram_din = cmd_din;

endmodule

// File: tb/tb_ram32_arbiter.sv
module tb_ram32_arbiter;
  logic        clk, rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_adr, b_adr;
  logic [32:0] a_din, b_din, a_dout, b_dout, ram_din, ram_dout;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic        ram_en, ram_we;
  logic [32:0] ram_adr;
  logic [32:0] mem [1024];

  int n_cmp = 0;
  int n_err = 0;

  ram32_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_dout(a_dout), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_dout(b_dout), .b_err(b_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // RAM model: async read, write on the rising edge
  assign ram_dout = mem[ram_adr[9:0]];
  always @(posedge clk) if (ram_en && ram_we) mem[ram_adr[9:0]] <= ram_din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish (observed timeout, expected $finish)");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 33'h1_0000_0000 + 33'(i);
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_adr = '0; a_din = '0;
    b_req = 0; b_we = 0; b_adr = '0; b_din = '0;
    tick(); tick();
    chk("rst_a_gnt", a_gnt, 0);     chk("rst_b_gnt", b_gnt, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_err", {a_err, b_err}, 0);
    chk("rst_a_dout", a_dout, 0);   chk("rst_b_dout", b_dout, 0);
    chk("rst_ram_en", ram_en, 0);   chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_adr", ram_adr, 0); chk("rst_ram_din", ram_din, 0);
    rst_n = 1'b1;

    // 1: A write 5, then A read 5
    a_req = 1; a_we = 1; a_adr = 10'd5; a_din = 33'h1_2345_6789;
    tick();
    chk("t1_a_gnt", a_gnt, 1);      chk("t1_b_gnt", b_gnt, 0);
    chk("t1_ram_en", ram_en, 1);    chk("t1_ram_we", ram_we, 1);
    chk("t1_ram_adr", ram_adr, 5);  chk("t1_ram_din", ram_din, 33'h1_2345_6789);
    a_req = 0;
    tick();
    chk("t1_wr_no_rvalid", a_rvalid, 0); chk("t1_gnt_drop", a_gnt, 0);
    chk("t1_mem5", mem[5], 33'h1_2345_6789);
    a_req = 1; a_we = 0;
    tick();
    chk("t1_rd_gnt", a_gnt, 1); chk("t1_rd_en", ram_en, 1); chk("t1_rd_we", ram_we, 0);
    a_req = 0;
    tick();
    chk("t1_rvalid", a_rvalid, 1); chk("t1_a_dout", a_dout, 33'h1_2345_6789);
    tick();
    chk("t1_rvalid_pulse", a_rvalid, 0);

    // 2: both read, tie after reset -> A, B, A, B
    rst_n = 0; tick(); rst_n = 1;
    a_req = 1; a_we = 0; a_adr = 10'd5;
    b_req = 1; b_we = 0; b_adr = 10'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_gnt", {a_gnt, b_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("t2_rv_busy", {a_rvalid, b_rvalid}, 2'b00);
      tick();
      chk("t2_rvalid", {a_rvalid, b_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("t2_gnt_idle", {a_gnt, b_gnt}, 2'b00);
      if (k % 2 == 0) chk("t2_a_dout", a_dout, 33'h1_2345_6789);
      else            chk("t2_b_dout", b_dout, 33'h1_0000_0002);
    end
    a_req = 0; b_req = 0;

    // 3: B alone, three writes to 0,1,2 (B was served last and still wins)
    b_req = 1; b_we = 1;
    for (int k = 0; k < 3; k++) begin
      b_adr = 10'(k); b_din = 33'h0_AAAA_0000 + 33'(k);
      tick();
      chk("t3_gnt", {a_gnt, b_gnt}, 2'b01);
      chk("t3_ram_adr", ram_adr, 33'(k));
      chk("t3_ram_en", ram_en, 1);
      tick();
      chk("t3_no_rvalid", b_rvalid, 0); chk("t3_gnt_gap", b_gnt, 0);
    end
    b_req = 0;
    a_req = 1; a_we = 0; a_adr = 10'd2;
    tick();
    chk("t3_rd_gnt", a_gnt, 1);
    a_req = 0;
    tick();
    chk("t3_rd_rvalid", a_rvalid, 1); chk("t3_rd_dout", a_dout, 33'h0_AAAA_0002);

    // 4: A read at adr 1023 (out of range)
    a_req = 1; a_we = 0; a_adr = 10'd1023;
    tick();
    chk("t4_gnt", a_gnt, 1); chk("t4_ram_en", ram_en, 0);
    a_req = 0;
    tick();
    chk("t4_err", a_err, 1); chk("t4_no_rvalid", a_rvalid, 0);
    chk("t4_dout_kept", a_dout, 33'h0_AAAA_0002); chk("t4_b_err", b_err, 0);
    tick();
    chk("t4_err_pulse", a_err, 0);

    // 5: B read at adr 1022 (last legal)
    b_req = 1; b_we = 0; b_adr = 10'd1022;
    tick();
    chk("t5_gnt", b_gnt, 1); chk("t5_ram_en", ram_en, 1);
    chk("t5_ram_adr", ram_adr, 33'h0_0000_03FE);
    b_req = 0;
    tick();
    chk("t5_rvalid", b_rvalid, 1); chk("t5_err", b_err, 0);
    chk("t5_dout", b_dout, 33'h1_0000_03FE);

    // 6: reset during a granted write
    a_req = 1; a_we = 1; a_adr = 10'd7; a_din = 33'h1_DEAD_BEEF;
    tick();
    chk("t6_gnt", a_gnt, 1); chk("t6_en", ram_en, 1);
    a_req = 0; rst_n = 0;
    tick();
    chk("t6_ram_en", ram_en, 0);
    chk("t6_no_rvalid", a_rvalid, 0); chk("t6_no_err", a_err, 0);
    chk("t6_not_written", mem[7], 33'h1_0000_0007);
    rst_n = 1;
    tick();
    chk("t6_no_resp", {a_rvalid, a_err, a_gnt}, 3'b000);
    a_req = 1; a_we = 0; a_adr = 10'd5;
    b_req = 1; b_we = 0; b_adr = 10'd2;
    tick();
    chk("t6_tie_a", {a_gnt, b_gnt}, 2'b10);
    a_req = 0; b_req = 0;
    tick();
    chk("t6_rvalid", a_rvalid, 1); chk("t6_dout", a_dout, 33'h1_2345_6789);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
